// File: rtl/cntr_share_pkg.sv
// cntr_share_pkg: shared types, widths and count-step helper for cntr_share_arb
package cntr_share_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int LEN_W = 3;
  localparam int MAX_VAL_DEF = 12;
  localparam int W_DEF = 4;
  function automatic int unsigned next_count(int unsigned c, logic up, int unsigned max_val);
    return up ? (c == max_val ? 0 : c + 1) : (c == 0 ? max_val : c - 1);
  endfunction
endpackage

// File: rtl/cntr_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker searching upward from ptr
module rr_pick #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          valid
);
  // scan from farthest to nearest so the nearest requester at or after ptr wins
  always_comb begin
    winner = '0;
    valid = |req;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) winner = PW'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/cntr_share_arb.sv
// cntr_share_arb: round-robin shared modulo up/down counter sequencer
module cntr_share_arb
  import cntr_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MAX_VAL = MAX_VAL_DEF,
  parameter int W = W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       dir,
  input  logic [LEN_W*N_REQ-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [W-1:0]           count,
  output logic                   wrap,
  output logic                   busy
);
  localparam int PW = $clog2(N_REQ);
  state_t state, state_n;
  logic [PW-1:0] ptr, win, pick;
  logic [LEN_W-1:0] rem;
  logic up, valid;
  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (.req(req), .ptr(ptr), .winner(pick), .valid(valid));
  // next state plus outputs decoded purely from registers
  always_comb begin
    state_n = state;
    if (state == IDLE && valid) state_n = RUN;
    if (state == RUN && rem == '0) state_n = IDLE;
    busy = state == RUN;
    grant = busy ? N_REQ'(1) << win : '0;
    done = rem == '0 ? grant : '0;
  end
  // state register, burst capture on grant and one count step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      up <= 1'b0;
      rem <= '0;
      count <= '0;
      wrap <= 1'b0;
    end else begin
      state <= state_n;
      wrap <= 1'b0;
      if (state == IDLE && valid) begin
        win <= pick;
        up <= dir[pick];
        rem <= len[LEN_W*pick +: LEN_W];
      end
      if (state == RUN) begin
        count <= W'(next_count(32'(count), up, MAX_VAL));
        wrap <= up ? count == W'(MAX_VAL) : count == '0;
        if (rem == '0) ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
        else rem <= rem - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cntr_share_arb.sv
// tb_cntr_share_arb: directed and random stimulus against a burst-level reference model
module tb_cntr_share_arb;
  localparam int N = 4;
  localparam int MV = 12;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, dir, grant, done;
  logic [3*N-1:0] len;
  logic [W-1:0] count;
  logic wrap, busy;
  int n_chk = 0;
  int n_pass = 0;
  int m_busy = 0, m_owner = 0, m_left = 0, m_up = 0, m_count = 0, m_ptr = 0, m_wrap = 0;
  cntr_share_arb #(.N_REQ(N), .MAX_VAL(MV), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .len(len),
    .grant(grant), .done(done), .count(count), .wrap(wrap), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
  endtask
  task automatic step(logic r, logic [N-1:0] rq, logic [N-1:0] d, logic [3*N-1:0] l);
    int found;
    rst = r;
    req = rq;
    dir = d;
    len = l;
    if (r) begin
      m_busy = 0; m_count = 0; m_ptr = 0; m_wrap = 0; m_left = 0;
    end else if (m_busy != 0) begin
      m_count = m_up != 0 ? (m_count + 1) % (MV + 1) : (m_count + MV) % (MV + 1);
      m_wrap = int'(m_count == (m_up != 0 ? 0 : MV));
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end else begin
      m_wrap = 0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (found == 0 && rq[idx]) begin
          found = 1;
          m_busy = 1;
          m_owner = idx;
          m_up = int'(d[idx]);
          m_left = int'(l[3*idx +: 3]) + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("grant", int'(grant), m_busy != 0 ? (1 << m_owner) : 0);
    chk("done", int'(done), (m_busy != 0 && m_left == 1) ? (1 << m_owner) : 0);
    chk("count", int'(count), m_count);
    chk("wrap", int'(wrap), m_wrap);
    chk("busy", int'(busy), m_busy);
    chk("onehot", int'($onehot0(grant)), 1);
  endtask
  function automatic logic [3*N-1:0] all_len(int v);
    return {N{3'(v)}};
  endfunction
  initial begin
    step(1'b1, '0, '0, '0);
    step(1'b1, '0, '0, '0);
    step(1'b0, 4'b0001, 4'b0001, all_len(2));
    repeat (4) step(1'b0, '0, '0, '0);
    step(1'b0, 4'b0010, 4'b1111, all_len(7));
    repeat (9) step(1'b0, '0, '0, '0);
    step(1'b0, 4'b0010, 4'b1111, all_len(3));
    repeat (5) step(1'b0, '0, '0, '0);
    step(1'b0, 4'b0100, 4'b0000, all_len(2));
    repeat (4) step(1'b0, '0, '0, '0);
    repeat (12) step(1'b0, 4'b1111, 4'b1111, all_len(0));
    repeat (3) step(1'b0, '0, '0, '0);
    repeat (2) step(1'b0, 4'b1000, 4'b1000, all_len(4));
    repeat (6) step(1'b0, '0, '0, '0);
    repeat (3) step(1'b0, 4'b0001, 4'b0001, all_len(7));
    step(1'b1, 4'b0001, 4'b0001, all_len(7));
    step(1'b0, '0, '0, '0);
    repeat (3) step(1'b0, 4'b1111, 4'b0000, all_len(0));
    repeat (3000)
      step($urandom_range(0, 60) == 0, N'($urandom), N'($urandom), (3*N)'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cntr_share_arb.md
# cntr_share_arb

Round-robin arbiter and sequencer that shares one modulo-(MAX_VAL+1) up/down count register among N_REQ requesters. Each requester asks for a burst of 1–8 steps in a chosen direction. The block grants one requester at a time, then steps the shared count once per cycle for the whole burst. It signals completion and wrap events, and sits between control FSMs and the shared count value they consume.

## Interface
- N_REQ, 4, number of requesters (2..8)
- MAX_VAL, 12, highest count value; count range 0..MAX_VAL
- W, 4, count width; must satisfy 2**W > MAX_VAL
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  request per requester; hold until own done pulse
- dir  in  N_REQ  direction per requester, 1 = up, 0 = down; sampled at grant
- len  in  3*N_REQ  burst length minus one per requester, slice [3i+2:3i]; sampled at grant
- grant  out  N_REQ  one-hot, or zero when idle; high for whole burst
- done  out  N_REQ  one-cycle pulse on last step cycle of the burst
- count  out  W  shared count value
- wrap  out  1  one-cycle pulse when count shows a wrapped value
- busy  out  1  high while in RUN

## Operation
- FSM has two states, IDLE and RUN.
- IDLE behaviour:
  - If any req bit is high, pick the winner by round-robin, searching from ptr upward modulo N_REQ.
  - On the next edge: grant ← onehot(winner), latch dir[winner] and len[winner] into rem, go to RUN.
  - If no req bit is high, stay in IDLE with grant = 0.
- RUN behaviour, on every edge:
  - Step count: up wraps MAX_VAL→0, down wraps 0→MAX_VAL.
  - If rem == 0: clear grant, set ptr ← winner+1 (mod N_REQ), return to IDLE.
  - Otherwise: rem ← rem−1.
- done[i] = grant[i] & (state == RUN) & (rem == 0). It is decoded from registers only, with no combinational path from inputs.
- busy = (state == RUN).
- req, dir and len are ignored during RUN. A requester that drops req mid-burst still gets its full burst and its done pulse.
- A requester that drops req while the block is in IDLE before the grant edge is simply not considered.
- wrap is registered: it is high in the cycle where count first shows the wrapped value (0 after an up-wrap, MAX_VAL after a down-wrap).
- Count arithmetic is W-bit unsigned; count never leaves 0..MAX_VAL.
- Reset values: count = 0, grant = 0, done = 0, wrap = 0, busy = 0, ptr = 0, rem = 0, state = IDLE.
- Reset mid-burst aborts the burst with no done pulse. Count returns to 0.

## Timing
- req high in IDLE cycle T → grant and busy high from T+1.
- Burst of L = len+1 steps occupies RUN cycles T+1..T+L.
- count shows the k-th step result in cycle T+1+k; the final value appears in cycle T+L+1.
- done is high in cycle T+L. grant is low from T+L+1.
- The block is back in IDLE in cycle T+L+1. The next grant is no earlier than T+L+2, so there is always one IDLE cycle between bursts.
- Throughput is L steps per L+1 cycles.
- Arbitration latency after request (worst case): (N_REQ−1) × 9 + 1 cycles.

## Structure
- Package cntr_share_pkg holds:
  - state enum (IDLE, RUN);
  - LEN_W = 3;
  - defaults for MAX_VAL and W;
  - the function for the next count value given dir.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are req and ptr; outputs are winner index and a valid bit.
- All other logic lives in cntr_share_arb.

## Test plan
- After reset, req = 0001, dir[0] = 1, len[0] = 2 → grant = 0001 for 3 cycles; count goes 0→1→2→3; done[0] pulses once on the third RUN cycle; busy falls after it.
- count = 11, req = 0010, dir[1] = 1, len[1] = 3 → count 11→12→0→1→2; wrap high exactly in the cycle count = 0.
- count = 1, req = 0100, dir[2] = 0, len[2] = 2 → count 1→0→12→11; wrap high in the cycle count = 12.
- req = 1111 held, all len = 0 → grants in order 0001, 0010, 0100, 1000, 0001 with one IDLE cycle between each; grant is never multi-hot.
- Requester 3 drops req on the second RUN cycle of a len = 4 burst → all 5 steps execute and done[3] still pulses.
- rst asserted in the middle of a len = 7 burst → next cycle count = 0, grant = 0, busy = 0, no done pulse; the next arbitration starts from ptr = 0.
